// File: rtl/horiz_vert_timing_gen.sv
// rtl/horiz_vert_timing_gen.sv - horizontal/vertical raster timing generator with sync, blanking and frame strobes
module horiz_vert_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Totals must be representable in the counter width.
    if (((64'(H_TOTAL) >> CNT_W) != 64'd0) || ((64'(V_TOTAL) >> CNT_W) != 64'd0)) begin : g_width_check
        $error("horiz_vert_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ON      = 1'(SYNC_POL);

    logic [CNT_W-1:0] h_count_q, h_count_d;
    logic [CNT_W-1:0] v_count_q, v_count_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap;
    logic             v_wrap;

    // Next-state: horizontal counter wraps at H_TOTAL-1, vertical steps on each horizontal wrap.
    always_comb begin
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        h_wrap        = (h_count_q == H_LAST);
        v_wrap        = (v_count_q == V_LAST);
        frame_start_d = 1'b0;
        if (pix_en) begin
            if (h_wrap) begin
                h_count_d = '0;
                if (v_wrap) begin
                    v_count_d     = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_count_d = v_count_q + CNT_W'(1);
                end
            end else begin
                h_count_d = h_count_q + CNT_W'(1);
            end
        end
    end

    // Position counters and the frame strobe; reset forces the origin immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count_q     <= '0;
            v_count_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_count     = h_count_q;
    assign v_count     = v_count_q;
    assign frame_start = frame_start_q;
    assign line_end    = pix_en && h_wrap;
    assign video_on    = (h_count_q < H_ACT_END) && (v_count_q < V_ACT_END);
    assign hsync       = ((h_count_q >= H_SYNC_FIRST) && (h_count_q <= H_SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;
    assign vsync       = ((v_count_q >= V_SYNC_FIRST) && (v_count_q <= V_SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;

endmodule

// File: tb/tb_horiz_vert_timing_gen.sv
// tb/tb_horiz_vert_timing_gen.sv - randomized self-checking bench for horiz_vert_timing_gen
module tb_horiz_vert_timing_gen;

    localparam int AHT = 800;
    localparam int AVT = 525;
    localparam int BHT = 8;
    localparam int BVT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, pe_a = 1'b0;
    logic [15:0] h_a, v_a;
    logic        hs_a, vs_a, vo_a, le_a, fs_a;
    logic        rst_b = 1'b1, pe_b = 1'b0;
    logic [15:0] h_b, v_b;
    logic        hs_b, vs_b, vo_b, le_b, fs_b;

    horiz_vert_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .pix_en(pe_a), .h_count(h_a), .v_count(v_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .line_end(le_a), .frame_start(fs_a)
    );

    horiz_vert_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .CNT_W(16)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix_en(pe_b), .h_count(h_b), .v_count(v_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .line_end(le_b), .frame_start(fs_b)
    );

    int errors = 0;
    int checks = 0;
    // Reference: number of ticks since reset release, plus the expected strobe for this cycle.
    int   n_a = 0, n_b = 0;
    logic fsx_a = 1'b0, fsx_b = 1'b0;

    function automatic logic sync_lvl(input int pos, input int act, input int fp, input int sw, input logic pol);
        return ((pos >= act + fp) && (pos < act + fp + sw)) ? pol : ~pol;
    endfunction

    function automatic logic [36:0] model_a(input int n, input logic pe, input logic fsx);
        int eh, ev;
        eh = n % AHT;
        ev = (n / AHT) % AVT;
        return {16'(eh), 16'(ev), sync_lvl(eh, 640, 16, 96, 1'b0), sync_lvl(ev, 480, 10, 2, 1'b0),
                ((eh < 640) && (ev < 480)), (pe && (eh == AHT - 1)), fsx};
    endfunction

    function automatic logic [36:0] model_b(input int n, input logic pe, input logic fsx);
        int eh, ev;
        eh = n % BHT;
        ev = (n / BHT) % BVT;
        return {16'(eh), 16'(ev), sync_lvl(eh, 4, 1, 2, 1'b1), sync_lvl(ev, 3, 1, 1, 1'b1),
                ((eh < 4) && (ev < 3)), (pe && (eh == BHT - 1)), fsx};
    endfunction

    task automatic test_reset();
        logic [36:0] got_a, got_b;
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int c = 0; c < 4; c++) begin
            pe_a = 1'($urandom_range(0, 1));
            pe_b = 1'($urandom_range(0, 1));
            #1;
            got_a = {h_a, v_a, hs_a, vs_a, vo_a, le_a, fs_a};
            got_b = {h_b, v_b, hs_b, vs_b, vo_b, le_b, fs_b};
            checks++;
            if (got_a !== {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_a cyc=%0d got=%h", c, got_a);
            end
            checks++;
            if (got_b !== {16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_b cyc=%0d got=%h", c, got_b);
            end
            @(negedge clk);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        n_a = 0; fsx_a = 1'b0;
        n_b = 0; fsx_b = 1'b0;
    endtask

    task automatic test_default_line();
        logic [36:0] got, exp;
        int hs_low, le_cnt;
        hs_low = 0;
        le_cnt = 0;
        for (int c = 0; c < 2 * AHT + 50; c++) begin
            pe_a = 1'b1;
            #1;
            got = {h_a, v_a, hs_a, vs_a, vo_a, le_a, fs_a};
            exp = model_a(n_a, pe_a, fsx_a);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL default_line cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (c < AHT && hs_a == 1'b0) hs_low++;
            if (le_a) le_cnt++;
            if (c == 1) begin
                checks++;
                if (h_a !== 16'd1) begin
                    errors++;
                    $display("FAIL first_tick got=%0d exp=1", h_a);
                end
            end
            @(posedge clk);
            if (pe_a) n_a++;
            fsx_a = pe_a && ((n_a % (AHT * AVT)) == 0);
            @(negedge clk);
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL hsync_width got=%0d exp=96", hs_low);
        end
        checks++;
        if (le_cnt != 2) begin
            errors++;
            $display("FAIL line_end_count got=%0d exp=2", le_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [36:0] got, exp;
        // Restart, then run to (h=400, v=1) before hitting reset mid-cycle.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        n_a = 0; fsx_a = 1'b0;
        for (int c = 0; c < AHT + 400; c++) begin
            pe_a = 1'b1;
            #1;
            got = {h_a, v_a, hs_a, vs_a, vo_a, le_a, fs_a};
            exp = model_a(n_a, pe_a, fsx_a);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, got, exp);
            end
            @(posedge clk);
            if (pe_a) n_a++;
            fsx_a = pe_a && ((n_a % (AHT * AVT)) == 0);
            @(negedge clk);
        end
        checks++;
        if (h_a !== 16'd400 || v_a !== 16'd1) begin
            errors++;
            $display("FAIL reach_point got=(%0d,%0d) exp=(400,1)", h_a, v_a);
        end
        #2 rst_a = 1'b1;
        #1;
        got = {h_a, v_a, hs_a, vs_a, vo_a, le_a, fs_a};
        checks++;
        if (got !== {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%h", got);
        end
        @(negedge clk);
        rst_a = 1'b0;
        n_a = 0; fsx_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            pe_a = 1'b1;
            #1;
            got = {h_a, v_a, hs_a, vs_a, vo_a, le_a, fs_a};
            exp = model_a(n_a, pe_a, fsx_a);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", c, got, exp);
            end
            @(posedge clk);
            if (pe_a) n_a++;
            fsx_a = pe_a && ((n_a % (AHT * AVT)) == 0);
            @(negedge clk);
        end
    endtask

    task automatic test_slow_tick();
        logic [36:0] got, exp;
        int le_cnt, exp_le;
        le_cnt = 0;
        exp_le = 0;
        for (int c = 0; c < 4 * AHT + 100; c++) begin
            pe_a = (c % 4 == 0);
            #1;
            got = {h_a, v_a, hs_a, vs_a, vo_a, le_a, fs_a};
            exp = model_a(n_a, pe_a, fsx_a);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL slow_tick cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (le_a) le_cnt++;
            @(posedge clk);
            if (pe_a) begin
                n_a++;
                if (n_a % AHT == 0) exp_le++;
            end
            fsx_a = pe_a && ((n_a % (AHT * AVT)) == 0);
            @(negedge clk);
        end
        checks++;
        if (le_cnt != exp_le) begin
            errors++;
            $display("FAIL slow_line_end got=%0d exp=%0d", le_cnt, exp_le);
        end
    endtask

    task automatic test_small_frame();
        logic [36:0] got, exp;
        int first_fs, fs_cnt;
        first_fs = -1;
        fs_cnt = 0;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        n_b = 0; fsx_b = 1'b0;
        for (int c = 0; c < 200; c++) begin
            pe_b = 1'b1;
            #1;
            got = {h_b, v_b, hs_b, vs_b, vo_b, le_b, fs_b};
            exp = model_b(n_b, pe_b, fsx_b);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL small_frame cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (fs_b) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = c;
            end
            @(posedge clk);
            if (pe_b) n_b++;
            fsx_b = pe_b && ((n_b % (BHT * BVT)) == 0);
            @(negedge clk);
        end
        checks++;
        if (first_fs != 48) begin
            errors++;
            $display("FAIL first_frame_start got=%0d exp=48", first_fs);
        end
        checks++;
        if (fs_cnt != 4) begin
            errors++;
            $display("FAIL frame_start_count got=%0d exp=4", fs_cnt);
        end
    endtask

    task automatic test_random_tick();
        logic [36:0] got, exp;
        for (int c = 0; c < 1500; c++) begin
            pe_b = 1'($urandom_range(0, 3) == 0 || c % 7 == 0);
            #1;
            got = {h_b, v_b, hs_b, vs_b, vo_b, le_b, fs_b};
            exp = model_b(n_b, pe_b, fsx_b);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_tick cyc=%0d got=%h exp=%h", c, got, exp);
            end
            @(posedge clk);
            if (pe_b) n_b++;
            fsx_b = pe_b && ((n_b % (BHT * BVT)) == 0);
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_default_line();
        test_reset_mid_frame();
        test_slow_tick();
        test_small_frame();
        test_random_tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
